// File: rtl/lzd_norm_seq.sv
// Iterative mantissa normalizer: shifts left CHUNK bits per cycle until the MSB is set.
// Define LZD_NORM_DENORM_EN to clamp the shift at exponent zero and report denormals.
module lzd_norm_seq #(
  parameter int WIDTH = 24,
  parameter int CHUNK = 4,
  parameter int EXP_W = 8,
  parameter int LZC_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src,
  input  logic [EXP_W-1:0] exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dst,
  output logic [EXP_W-1:0] exp_out,
  output logic [LZC_W-1:0] lzc,
  output logic             zero,
  output logic             denorm
);
  localparam int ZW = $clog2(CHUNK+1);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] m_q, m_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic [LZC_W-1:0] cnt_q, cnt_d;
  logic             zsrc_q;
  logic [WIDTH-1:0] dst_q;
  logic [EXP_W-1:0] exp_q;
  logic [LZC_W-1:0] lzc_q;
  logic             zero_q, denorm_q;

  logic [CHUNK-1:0] chunk;
  logic [ZW-1:0]    z, s;
  logic             clamp, fin;

  assign chunk = m_q[WIDTH-1 -: CHUNK];

  // Highest set bit wins because the loop walks upward and overwrites.
  always_comb begin
    z = ZW'(CHUNK);
    for (int i = 0; i < CHUNK; i++)
      if (chunk[i]) z = ZW'(CHUNK-1-i);
  end

`ifdef LZD_NORM_DENORM_EN
  assign clamp = (EXP_W'(z) > e_q);
  assign s     = clamp ? ZW'(e_q) : z;
`else
  assign clamp = 1'b0;
  assign s     = z;
`endif

  // An all-zero chunk means more zeros may follow; anything else ends the search.
  assign fin   = (z != ZW'(CHUNK)) || clamp;
  assign m_d   = m_q << s;
  assign e_d   = e_q - EXP_W'(s);
  assign cnt_d = cnt_q + LZC_W'(s);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      m_q      <= '0;
      e_q      <= '0;
      cnt_q    <= '0;
      zsrc_q   <= 1'b0;
      dst_q    <= '0;
      exp_q    <= '0;
      lzc_q    <= '0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            m_q     <= src;
            e_q     <= exp_in;
            cnt_q   <= '0;
            zsrc_q  <= (src == '0);
            state_q <= NORM;
          end
        end
        NORM: begin
          // A zero mantissa spends its single cycle here without shifting.
          if (zsrc_q) begin
            dst_q    <= '0;
            exp_q    <= '0;
            lzc_q    <= LZC_W'(WIDTH);
            zero_q   <= 1'b1;
            denorm_q <= 1'b0;
            state_q  <= DONE;
          end else begin
            m_q   <= m_d;
            e_q   <= e_d;
            cnt_q <= cnt_d;
            if (fin) begin
              dst_q    <= m_d;
              exp_q    <= e_d;
              lzc_q    <= cnt_d;
              zero_q   <= 1'b0;
              denorm_q <= clamp;
              state_q  <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dst       = dst_q;
  assign exp_out   = exp_q;
  assign lzc       = lzc_q;
  assign zero      = zero_q;
  assign denorm    = denorm_q;

endmodule

// File: tb/tb_lzd_norm_seq.sv
// Scoreboard bench for lzd_norm_seq: driver pushes model results, monitor pops on handshake.
module tb_lzd_norm_seq;
  localparam int W  = 24;
  localparam int C  = 4;
  localparam int E  = 8;
  localparam int LW = $clog2(W+1);
  localparam int PER = 10;
  localparam int HALF = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  src = '0;
  logic [E-1:0]  exp_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  dst;
  logic [E-1:0]  exp_out;
  logic [LW-1:0] lzc;
  logic          zero, denorm;

  lzd_norm_seq #(.WIDTH(W), .CHUNK(C), .EXP_W(E), .LZC_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .src(src), .exp_in(exp_in), .out_valid(out_valid), .out_ready(out_ready),
    .dst(dst), .exp_out(exp_out), .lzc(lzc), .zero(zero), .denorm(denorm)
  );

  always #HALF clk = ~clk;

  typedef struct {
    logic [W-1:0]  dst;
    logic [E-1:0]  ex;
    logic [LW-1:0] lzc;
    logic          zero;
    logic          den;
    int            k;
    time           t;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   rdy_mode = 2;   // 0 random, 1 hold low, 2 hold high

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: whole-word leading-zero count, then clamp against the exponent.
  function automatic exp_t model(input logic [W-1:0] s, input logic [E-1:0] e);
    exp_t x;
    int   L, sh;
    L = W;
    for (int i = 0; i < W; i++) if (s[i]) L = W-1-i;
    x.t = 0;
    if (L == W) begin
      x.dst = '0; x.ex = '0; x.lzc = LW'(W); x.zero = 1'b1; x.den = 1'b0; x.k = 1;
    end else begin
      sh = L; x.den = 1'b0; x.k = L/C + 1;
`ifdef LZD_NORM_DENORM_EN
      if (int'(e) < L) begin
        sh = int'(e); x.den = 1'b1; x.k = int'(e)/C + 1;
      end
`endif
      x.dst  = s << sh;
      x.ex   = e - E'(sh);
      x.lzc  = LW'(sh);
      x.zero = 1'b0;
    end
    return x;
  endfunction

  task automatic send(input logic [W-1:0] s, input logic [E-1:0] e);
    exp_t x;
    int   n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk(1'b0, "in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    src = s;
    exp_in = e;
    @(posedge clk);
    x = model(s, e);
    x.t = $time;
    sb.push_back(x);
    #1;
    in_valid = 1'b0;
    src = W'($urandom);
    exp_in = E'($urandom);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(out_valid, "wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor
  exp_t cur;
  bit   have = 0, prev_v = 0, hs_prev = 0;
  int   lat;
  always @(negedge clk) begin
    if (!rst_n) begin
      have = 0; prev_v = 0; hs_prev = 0;
    end else begin
      if (hs_prev) chk(in_ready == 1'b1, "in_ready_after_hs", 32'(in_ready), 32'd1);
      hs_prev = 0;
      if (out_valid) begin
        if (!prev_v) begin
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_out_valid", 32'(out_valid), 32'd0);
          end else begin
            cur = sb[0];
            have = 1;
            lat = int'(($time - cur.t - HALF) / PER);
            chk(lat == cur.k, "latency", 32'(lat), 32'(cur.k));
          end
        end
        if (have) begin
          chk(dst == cur.dst, "dst", 32'(dst), 32'(cur.dst));
          chk(exp_out == cur.ex, "exp_out", 32'(exp_out), 32'(cur.ex));
          chk(lzc == cur.lzc, "lzc", 32'(lzc), 32'(cur.lzc));
          chk(zero == cur.zero, "zero", 32'(zero), 32'(cur.zero));
          chk(denorm == cur.den, "denorm", 32'(denorm), 32'(cur.den));
          chk(in_ready == 1'b0, "in_ready_in_done", 32'(in_ready), 32'd0);
        end
        if (out_ready) begin
          if (have) void'(sb.pop_front());
          have = 0;
          hs_prev = 1;
        end
      end
      prev_v = out_valid && !out_ready;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] r;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'd0);
    chk(in_ready == 1'b0, "rst_in_ready", 32'(in_ready), 32'd0);
    chk({dst, exp_out, lzc, zero, denorm} == '0, "rst_outputs", 32'(dst), 32'd0);
    rst_n = 1'b1;

    // Directed vectors
    rdy_mode = 2;
    send(24'h800000, 8'd100);
    send(24'h000001, 8'd100);
    send(24'h000000, 8'd50);
    send(24'h000100, 8'd5);
    send(24'h000100, 8'd4);
    send(24'h000100, 8'd0);
    send(24'h400000, 8'd0);
    send(24'h0FFFFF, 8'd255);

    // Backpressure: hold out_ready low for three DONE cycles
    @(negedge clk);
    while (sb.size() != 0) @(negedge clk);
    rdy_mode = 1;
    send(24'h800000, 8'd100);
    wait_valid();
    repeat (3) @(negedge clk);
    rdy_mode = 2;

    // Reset in the middle of a long normalization
    send(24'h000001, 8'd100);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    chk(out_valid == 1'b0, "midrst_out_valid", 32'(out_valid), 32'd0);
    chk(in_ready == 1'b0, "midrst_in_ready", 32'(in_ready), 32'd0);
    chk(dst == '0, "midrst_dst", 32'(dst), 32'd0);
    chk({exp_out, lzc, zero, denorm} == '0, "midrst_misc", 32'({exp_out, lzc, zero, denorm}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(24'h000001, 8'd100);

    // Randomized traffic with random backpressure
    rdy_mode = 0;
    for (int i = 0; i < 200; i++) begin
      r = W'($urandom) >> $urandom_range(0, W);
      send(r, ($urandom_range(0, 1) != 0) ? E'($urandom_range(0, 30)) : E'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    rdy_mode = 2;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(sb.size() == 0, "drain", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
